// File: rtl/pixel_pkg.sv
// Shared types and sizing helpers for the parametrised pixel framebuffer.
package pixel_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FILL  = 2'd1,
    IDLE  = 2'd2
  } fb_state_t;

  localparam logic [2:0] DEFAULT_BG_COLOR = 3'b111;

  function automatic int unsigned npix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned addr_bits(input int unsigned w, input int unsigned h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/pixel_framebuffer_if.sv
// Brush/clear write side and VGA read side of the pixel framebuffer.
interface pixel_framebuffer_if #(
  parameter int unsigned CBITS  = 3,
  parameter int unsigned WXBITS = 8,
  parameter int unsigned RXBITS = 10
);
  logic              clear;
  logic [CBITS-1:0]  clearColor;
  logic              brush;
  logic [WXBITS-1:0] wx;
  logic [WXBITS-1:0] wy;
  logic [CBITS-1:0]  newColor;
  logic [RXBITS-1:0] rx;
  logic [RXBITS-1:0] ry;
  logic [CBITS-1:0]  colorCode;
  logic              busy;

  modport master (
    output clear, clearColor, brush, wx, wy, newColor, rx, ry,
    input  colorCode, busy
  );

  modport slave (
    input  clear, clearColor, brush, wx, wy, newColor, rx, ry,
    output colorCode, busy
  );
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one synchronous write, one synchronous read-first read.
module fb_ram #(
  parameter int unsigned DEPTH = 40000,
  parameter int unsigned DW    = 3,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_framebuffer.sv
// WIDTH x HEIGHT colour-code framebuffer with bounds-checked brush writes,
// registered out-of-bounds read masking and a clear/fill sweep after reset.
module pixel_framebuffer
  import pixel_pkg::*;
#(
  parameter int unsigned      WIDTH    = 200,
  parameter int unsigned      HEIGHT   = 200,
  parameter int unsigned      CBITS    = 3,
  parameter int unsigned      WXBITS   = 8,
  parameter int unsigned      RXBITS   = 10,
  parameter logic [CBITS-1:0] BG_COLOR = CBITS'(DEFAULT_BG_COLOR)
) (
  input  logic               clk,
  input  logic               nreset,
  pixel_framebuffer_if.slave bus
);
  localparam int unsigned NPIX = npix(WIDTH, HEIGHT);
  localparam int unsigned AW   = addr_bits(WIDTH, HEIGHT);
  localparam int unsigned WLW  = WXBITS + $clog2(WIDTH + 1) + 1;
  localparam int unsigned RLW  = RXBITS + $clog2(WIDTH + 1) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  fb_state_t        state_q, state_d;
  logic [CBITS-1:0] fill_q, fill_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             oob_q;

  logic             w_inb, r_oob;
  logic [WLW-1:0]   wlin;
  logic [RLW-1:0]   rlin;
  logic             busy;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [CBITS-1:0] ram_wdata, ram_rdata;
  logic [CBITS-1:0] color_out;

  // Linear addresses are formed wide enough to never overflow; only in-bounds
  // results ever reach the RAM, so the narrowing below is lossless.
  assign wlin  = WLW'(bus.wy) * WLW'(WIDTH) + WLW'(bus.wx);
  assign rlin  = RLW'(bus.ry) * RLW'(WIDTH) + RLW'(bus.rx);
  assign w_inb = (32'(bus.wx) < WIDTH) && (32'(bus.wy) < HEIGHT);
  assign r_oob = (32'(bus.rx) >= WIDTH) || (32'(bus.ry) >= HEIGHT);
  assign busy  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RESET: begin
        cnt_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        if (cnt_q == LAST_ADDR) state_d = IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      IDLE: begin
        if (bus.clear) begin
          fill_d  = bus.clearColor;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = AW'(wlin);
    ram_wdata = bus.newColor;
    if (state_q == FILL) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = fill_q;
    end else if (state_q == IDLE && bus.brush && w_inb && !bus.clear) begin
      ram_we = 1'b1;
    end
  end

  assign ram_raddr = r_oob ? '0 : AW'(rlin);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= RESET;
      fill_q  <= BG_COLOR;
      cnt_q   <= '0;
      oob_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      oob_q   <= r_oob;
    end
  end

  fb_ram #(
    .DEPTH (NPIX),
    .DW    (CBITS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    color_out = ram_rdata;
    if (oob_q)     color_out = BG_COLOR;
    else if (busy) color_out = fill_q;
  end

  assign bus.colorCode = color_out;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed bench for pixel_framebuffer on a 4x3 buffer.
module tb_pixel_framebuffer;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  pixel_framebuffer_if #(.CBITS(3), .WXBITS(8), .RXBITS(10)) bus ();

  pixel_framebuffer #(
    .WIDTH    (4),
    .HEIGHT   (3),
    .CBITS    (3),
    .WXBITS   (8),
    .RXBITS   (10),
    .BG_COLOR (3'b111)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    bus.wx = 8'(x); bus.wy = 8'(y); bus.newColor = c; bus.brush = 1'b1;
    tick();
    bus.brush = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int x, input int y, input logic [2:0] exp);
    bus.rx = 10'(x); bus.ry = 10'(y);
    tick();
    check(tag, 32'(bus.colorCode), 32'(exp));
  endtask

  task automatic scan(input string tag, input logic [2:0] exp);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        rd_check(tag, x, y, exp);
  endtask

  // Counts busy cycles; clear/brush are dropped after the first edge.
  task automatic run_fill(input int pulse_at, input logic [2:0] pulse_col,
                          input int stop_at, input logic [2:0] exp_col, output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      bus.clear = 1'b0;
      bus.brush = 1'b0;
      if (!bus.busy) return;
      cnt++;
      if (cnt == 1) check("fill_color", 32'(bus.colorCode), 32'(exp_col));
      if (cnt == pulse_at) begin
        bus.clear = 1'b1;
        bus.clearColor = pulse_col;
      end
      if (cnt == stop_at) return;
    end
  endtask

  task automatic start_clear(input logic [2:0] col);
    bus.rx = 10'd1; bus.ry = 10'd1;
    bus.clear = 1'b1; bus.clearColor = col;
  endtask

  initial begin
    bus.clear = 1'b0; bus.clearColor = '0; bus.brush = 1'b0;
    bus.wx = '0; bus.wy = '0; bus.newColor = '0;
    bus.rx = 10'd1; bus.ry = 10'd1;
    #1 nreset = 1'b0;
    #2;
    check("reset_busy", 32'(bus.busy), 32'd1);
    check("reset_color", 32'(bus.colorCode), 32'h7);
    tick();
    tick();
    nreset = 1'b1;
    run_fill(0, 3'b000, 0, 3'b111, n);
    check("reset_fill_len", n, 12);
    scan("post_reset_scan", 3'b111);

    wr(2, 1, 3'b010);
    rd_check("brush_2_1", 2, 1, 3'b010);
    rd_check("neighbour_1_1", 1, 1, 3'b111);

    wr(0, 0, 3'b010);
    wr(0, 1, 3'b010);
    rd_check("oob_x", 4, 0, 3'b111);
    rd_check("oob_y", 0, 3, 3'b111);
    wr(4, 0, 3'b011);
    rd_check("addr4_kept", 0, 1, 3'b010);
    rd_check("addr0_kept", 0, 0, 3'b010);

    bus.wx = 8'd3; bus.wy = 8'd2; bus.newColor = 3'b101; bus.brush = 1'b1;
    bus.rx = 10'd3; bus.ry = 10'd2;
    tick();
    bus.brush = 1'b0;
    check("read_first_old", 32'(bus.colorCode), 32'h7);
    tick();
    check("read_first_new", 32'(bus.colorCode), 32'h5);

    start_clear(3'b001);
    bus.brush = 1'b1; bus.wx = 8'd0; bus.wy = 8'd0; bus.newColor = 3'b110;
    run_fill(0, 3'b000, 0, 3'b001, n);
    check("clear_fill_len", n, 12);
    scan("clear_scan", 3'b001);

    start_clear(3'b110);
    run_fill(5, 3'b100, 0, 3'b110, n);
    check("ignored_clear_len", n, 12);
    scan("ignored_clear_scan", 3'b110);

    start_clear(3'b010);
    run_fill(0, 3'b000, 6, 3'b010, n);
    check("pre_abort_len", n, 6);
    nreset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_color", 32'(bus.colorCode), 32'h7);
    tick();
    nreset = 1'b1;
    run_fill(0, 3'b000, 0, 3'b111, n);
    check("abort_refill_len", n, 12);
    scan("abort_scan", 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
- Parametrised successor to the brush-painted pixel store: a WIDTH x HEIGHT framebuffer of CBITS-wide colour codes.
- Painted by the brush/input path and read by the VGA scan path.
- Adds linear addressing for arbitrary dimensions, registered bounds checking aligned with read data, bounds-checked writes, and a hardware clear/fill sweep that also runs automatically after reset.

Parameters:
- WIDTH, 200, visible pixels per row.
- HEIGHT, 200, visible rows.
- CBITS, 3, colour code width.
- WXBITS, 8, write x/y coordinate width; must satisfy 2**WXBITS >= max(WIDTH, HEIGHT).
- RXBITS, 10, read (VGA counter) x/y coordinate width.
- BG_COLOR, 3'b111, border colour and post-reset fill colour.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- clear  in  1  single-cycle request: fill whole buffer with clearColor
- clearColor  in  CBITS  fill colour; sampled when clear is accepted
- brush  in  1  write strobe for (wx, wy)
- wx, wy  in  WXBITS each  write coordinates
- newColor  in  CBITS  write colour
- rx, ry  in  RXBITS each  read coordinates from VGA counters
- colorCode  out  CBITS  pixel colour for (rx, ry) presented one cycle earlier
- busy  out  1  high while a fill sweep is in progress

Behaviour:
- Storage: WIDTH*HEIGHT entries, address = y*WIDTH + x. The address multiply uses constant WIDTH and is computed at full width, with no truncation. RAM contents are not reset.
- Read path: 1-cycle latency.
  - Cycle N: register the RAM read of (rx, ry), plus an out-of-bounds flag (rx >= WIDTH or ry >= HEIGHT, unsigned compare).
  - Cycle N+1: colorCode = BG_COLOR if the flag is set; otherwise fillColor while busy; otherwise the RAM data.
  - Out-of-bounds reads must not index the RAM with a wrapped address (gate the address to 0).
- Write path: when brush=1, state is IDLE and wx < WIDTH and wy < HEIGHT, write newColor at the next edge. Out-of-bounds writes are silently dropped.
- Same-address read and write in one cycle: read-first, so colorCode shows the old value; the new value is visible on the next read.
- FSM states: RESET, FILL, IDLE.
  - RESET: entered asynchronously while nreset=0. fillColor=BG_COLOR, fill counter=0, busy=1, colorCode=BG_COLOR. On the first edge after release, go to FILL.
  - FILL: one write per cycle of fillColor at the counter address; counter increments. After address WIDTH*HEIGHT-1 is written, go to IDLE. busy=0 from the cycle after the last write. Duration is exactly WIDTH*HEIGHT cycles.
  - IDLE: busy=0. If clear=1, latch clearColor into fillColor, zero the counter, go to FILL; busy=1 on the next cycle.
- Simultaneous clear and brush in IDLE: clear wins and the brush write is dropped.
- clear while busy: ignored; no restart, fillColor unchanged.
- brush while busy: dropped.
- nreset asserted mid-FILL: abort immediately to RESET; a full BG_COLOR sweep follows release.
- Counter width: clog2(WIDTH*HEIGHT); no wrap past the last address.
- Reset values: colorCode = BG_COLOR, busy = 1, internal read registers = 0, OOB flag = 1.

Decomposition:
- Package pixel_pkg:
  - fb_state_t enum {RESET, FILL, IDLE}
  - localparam NPIX = WIDTH*HEIGHT and ADDR_BITS = $clog2(NPIX) as package functions/constants
  - the default BG_COLOR constant
- Sub-module fb_ram: one synchronous write port, one synchronous read port, read-first, parametrised depth and data width, inferring block RAM. No reset.
- Top level holds the FSM, address arithmetic, bounds logic and output mux.

Test Plan:
- Reset release, WIDTH=4, HEIGHT=3 -> busy=1 for exactly 12 cycles after release, then 0. A subsequent scan of all 12 in-bounds pixels returns 3'b111.
- After fill, brush at (2,1) with newColor=3'b010, then read (2,1) -> colorCode=3'b010 one cycle after rx/ry are presented. Read (1,1) returns 3'b111.
- Read (4,0) and (0,3) with the RAM holding 3'b010 at addresses 0 and 4 (the wrapped addresses) -> colorCode=BG_COLOR; a brush at (4,0) leaves address 4 unchanged.
- clear=1 with clearColor=3'b001 and brush=1 at (0,0) in the same cycle -> busy rises next cycle for 12 cycles; colorCode reads 3'b001 during busy; after busy falls, all pixels are 3'b001, including (0,0).
- clear pulsed again 5 cycles into a fill with clearColor=3'b100 -> ignored: fill completes at the original 12 cycles and all pixels hold the first colour.
- nreset pulsed low 6 cycles into a fill -> colorCode=BG_COLOR and busy=1 immediately; a full 12-cycle BG_COLOR sweep follows release.
